// File: rtl/perm16_inverter_if.sv
// Handshake bundle for perm16_inverter.
// Both channels use strict valid/ready: a transfer happens on a rising edge
// where valid and ready are both 1; valid never waits on ready, and the
// payload (seq_all, or inv_all/perm_err) is stable while valid is held.
// dbg_state mirrors the block's FSM encoding (0=IDLE, 1=SCAN, 2=DONE).
interface perm16_inverter_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] seq_all;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] inv_all;
  logic        perm_err;
  logic [1:0]  dbg_state;

  // Block side
  modport slave (
    input  in_valid, seq_all, out_ready,
    output in_ready, out_valid, inv_all, perm_err, dbg_state
  );

  // Environment side (producer of candidates, consumer of results)
  modport master (
    output in_valid, seq_all, out_ready,
    input  in_ready, out_valid, inv_all, perm_err, dbg_state
  );
endinterface

// File: rtl/perm16_inverter.sv
// perm16_inverter: inverts a permutation of 16 four-bit entries.
// A captured candidate is scanned one entry per cycle (16 cycles), writing
// inv[entry[idx]] := idx, so later duplicates overwrite earlier ones and
// unwritten entries stay 0. The result is held in DONE until consumed.
// Optional feature macro: PERM16_INV_CHECK_EN -- when defined, a 16-bit
// seen bitmap flags duplicate entries on perm_err; otherwise perm_err is 0.
module perm16_inverter (
  input  logic               clk,
  input  logic               rst,
  perm16_inverter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  idx_q;
  logic [63:0] seq_q;
  logic [63:0] inv_q;
  logic [3:0]  entry;

  assign entry = seq_q[{idx_q, 2'b00} +: 4];

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = SCAN;
      end
      SCAN: begin
        if (idx_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture on accept, then one inverse write per SCAN cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= 4'd0;
      seq_q <= 64'd0;
      inv_q <= 64'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            seq_q <= bus.seq_all;
            inv_q <= 64'd0;
            idx_q <= 4'd0;
          end
        end
        SCAN: begin
          inv_q[{entry, 2'b00} +: 4] <= idx_q;
          idx_q <= idx_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef PERM16_INV_CHECK_EN
  logic [15:0] seen_q;
  logic        err_q;

  // Duplicate detection: an entry already seen sets a sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seen_q <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            seen_q <= 16'd0;
            err_q  <= 1'b0;
          end
        end
        SCAN: begin
          seen_q[entry] <= 1'b1;
          if (seen_q[entry]) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.perm_err = err_q;
`else
  assign bus.perm_err = 1'b0;
`endif

  assign bus.inv_all   = inv_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_perm16_inverter.sv
// Testbench for perm16_inverter: directed patterns, random permutations and
// random (possibly duplicate) sequences against a search-based inverse model.
module tb_perm16_inverter;

  localparam int W = 65;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  logic [W-1:0] exp_q[$];

  perm16_inverter_if bus();

  perm16_inverter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: inverse entry e is the LAST index holding value e (0 if none);
  // error when any value occurs more than once.
  function automatic logic [W-1:0] ref_model(input logic [63:0] seq);
    logic [63:0] inv;
    logic [3:0]  v;
    int          cnt;
    logic        err;
    inv = '0;
    err = 1'b0;
    for (int e = 0; e < 16; e++) begin
      cnt = 0;
      for (int i = 15; i >= 0; i--) begin
        v = seq[4*i +: 4];
        if (v == 4'(e)) begin
          if (cnt == 0) inv[4*e +: 4] = 4'(i);
          cnt++;
        end
      end
      if (cnt > 1) err = 1'b1;
    end
`ifndef PERM16_INV_CHECK_EN
    err = 1'b0;
`endif
    return {err, inv};
  endfunction

  function automatic logic [63:0] rand_perm();
    int a[16];
    int j;
    int t;
    logic [63:0] s;
    for (int i = 0; i < 16; i++) a[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = a[i]; a[i] = a[j]; a[j] = t;
    end
    for (int i = 0; i < 16; i++) s[4*i +: 4] = 4'(a[i]);
    return s;
  endfunction

  // Drive one candidate, check latency, result, DONE hold for `hold` cycles
  task automatic do_txn(input logic [63:0] seq, input int hold, input bit rel_rst,
                        output int acc_cyc);
    int n;
    int tries;
    logic [W-1:0] exp;
    logic [63:0] inv0;
    logic err0;
    @(negedge clk);
    if (rel_rst) rst = 1'b1;
    tries = 0;
    while (!bus.in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    check("ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.seq_all  = seq;
    exp_q.push_back(ref_model(seq));
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.seq_all  = {$urandom, $urandom};
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.out_valid) break;
      check("scan_no_ready", 64'(bus.in_ready), 64'd0);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.seq_all  = {$urandom, $urandom};
    end
    check("latency", 64'(n), 64'd16);
    check("excl_ready", 64'(bus.in_ready), 64'd0);
    exp = exp_q.pop_front();
    check("inv_all", bus.inv_all, exp[63:0]);
    check("perm_err", 64'(bus.perm_err), 64'(exp[64]));
    inv0 = bus.inv_all;
    err0 = bus.perm_err;
    for (int k = 0; k < hold; k++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.seq_all   = {$urandom, $urandom};
      @(posedge clk);
      #1;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_inv", bus.inv_all, inv0);
      check("hold_err", 64'(bus.perm_err), 64'(err0));
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk);
    #1;
    check("post_valid", 64'(bus.out_valid), 64'd0);
    check("post_ready", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_inv"}, bus.inv_all, 64'd0);
    check({tag, "_err"}, 64'(bus.perm_err), 64'd0);
    check({tag, "_state"}, 64'(bus.dbg_state), 64'd0);
  endtask

  logic [63:0] s;
  int a0, a1, dummy;
  bit seen_valid;

  initial begin
    cyc = 0;
    checks = 0;
    failures = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.seq_all = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Identity, reversal, shift, all-zero
    for (int i = 0; i < 16; i++) s[4*i +: 4] = 4'(i);
    do_txn(s, 0, 1'b0, dummy);
    check("identity_direct", bus.inv_all, 64'hFEDCBA9876543210);
    for (int i = 0; i < 16; i++) s[4*i +: 4] = 4'(15 - i);
    do_txn(s, 2, 1'b0, dummy);
    for (int i = 0; i < 16; i++) s[4*i +: 4] = 4'((i + 3) % 16);
    do_txn(s, 5, 1'b0, dummy);
    s = '0;
    do_txn(s, 5, 1'b0, dummy);

    // Back-to-back spacing
    bus.out_ready = 1'b1;
    do_txn(rand_perm(), 0, 1'b0, a0);
    do_txn(rand_perm(), 0, 1'b0, a1);
    check("b2b_spacing", 64'(a1 - a0), 64'd18);

    // Reset during SCAN at idx=7
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.seq_all  = rand_perm();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_scan_state", 64'(bus.dbg_state), 64'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    seen_valid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen_valid = 1'b1;
    end
    check("no_stale_valid", 64'(seen_valid), 64'd0);

    // Acceptance on the first edge after release
    @(negedge clk);
    rst = 1'b0;
    do_txn(rand_perm(), 1, 1'b1, dummy);

    // Random mix of permutations and arbitrary sequences
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1) s = rand_perm();
      else s = {$urandom, $urandom};
      do_txn(s, $urandom_range(0, 5), 1'b0, dummy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
